// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ALU with valid/ready handshake, status flags and result accumulator
module alu_pipe #(
    parameter int                WIDTH   = 16,
    parameter logic [WIDTH-1:0]  ACC_RST = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic [2:0]       Control,
    input  logic             use_acc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic             Cout,
    output logic             zero,
    output logic             neg,
    output logic             ovf
);
    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
    logic             s1_cin_q, s1_cin_d, s1_use_acc_q, s1_use_acc_d;
    logic [2:0]       s1_ctl_q, s1_ctl_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d, acc_q, acc_d;
    logic             cout_q, cout_d, zero_q, zero_d, neg_q, neg_d, ovf_q, ovf_d;
    logic             adv2, accept;
    logic [WIDTH-1:0] b_eff, res;
    logic [WIDTH:0]   sum;
    logic             cy, ov;

    // Execute: operate on the issue register; B is swapped for ACC when requested
    always_comb begin
        b_eff = s1_use_acc_q ? acc_q : s1_b_q;
        sum   = '0;
        res   = '0;
        cy    = 1'b0;
        ov    = 1'b0;
        case (s1_ctl_q)
            3'b000: begin
                sum = {1'b0, s1_a_q} + {1'b0, b_eff} + {{WIDTH{1'b0}}, s1_cin_q};
                res = sum[WIDTH-1:0];
                cy  = sum[WIDTH];
                ov  = (s1_a_q[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != s1_a_q[WIDTH-1]);
            end
            3'b001: begin
                sum = {1'b0, s1_a_q} + {1'b0, ~b_eff} + {{WIDTH{1'b0}}, 1'b1};
                res = sum[WIDTH-1:0];
                cy  = sum[WIDTH];
                ov  = (s1_a_q[WIDTH-1] != b_eff[WIDTH-1]) && (sum[WIDTH-1] != s1_a_q[WIDTH-1]);
            end
            3'b010: res = s1_a_q & b_eff;
            3'b011: res = s1_a_q | b_eff;
            3'b100: res = s1_a_q ^ b_eff;
            3'b101: res = ~s1_a_q;
            3'b110: begin
                res = {s1_a_q[WIDTH-2:0], 1'b0};
                cy  = s1_a_q[WIDTH-1];
            end
            default: begin
                res = {1'b0, s1_a_q[WIDTH-1:1]};
                cy  = s1_a_q[0];
            end
        endcase
    end

    // Handshake and next-state: output stage holds under backpressure, issue stage refills as it drains
    always_comb begin
        adv2         = s1_valid_q && (!out_valid_q || out_ready);
        in_ready     = !s1_valid_q || adv2;
        accept       = in_valid && in_ready;
        s1_valid_d   = accept ? 1'b1 : (adv2 ? 1'b0 : s1_valid_q);
        s1_a_d       = accept ? A : s1_a_q;
        s1_b_d       = accept ? B : s1_b_q;
        s1_cin_d     = accept ? Cin : s1_cin_q;
        s1_ctl_d     = accept ? Control : s1_ctl_q;
        s1_use_acc_d = accept ? use_acc : s1_use_acc_q;
        out_valid_d  = adv2 ? 1'b1 : (out_ready ? 1'b0 : out_valid_q);
        result_d     = adv2 ? res : result_q;
        cout_d       = adv2 ? cy : cout_q;
        zero_d       = adv2 ? (res == '0) : zero_q;
        neg_d        = adv2 ? res[WIDTH-1] : neg_q;
        ovf_d        = adv2 ? ov : ovf_q;
        acc_d        = adv2 ? res : acc_q;
    end

    // Pipeline registers; reset drops any in-flight operation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_a_q       <= '0;
            s1_b_q       <= '0;
            s1_cin_q     <= 1'b0;
            s1_ctl_q     <= '0;
            s1_use_acc_q <= 1'b0;
            out_valid_q  <= 1'b0;
            result_q     <= '0;
            cout_q       <= 1'b0;
            zero_q       <= 1'b0;
            neg_q        <= 1'b0;
            ovf_q        <= 1'b0;
            acc_q        <= ACC_RST;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_a_q       <= s1_a_d;
            s1_b_q       <= s1_b_d;
            s1_cin_q     <= s1_cin_d;
            s1_ctl_q     <= s1_ctl_d;
            s1_use_acc_q <= s1_use_acc_d;
            out_valid_q  <= out_valid_d;
            result_q     <= result_d;
            cout_q       <= cout_d;
            zero_q       <= zero_d;
            neg_q        <= neg_d;
            ovf_q        <= ovf_d;
            acc_q        <= acc_d;
        end
    end

    assign out_valid = out_valid_q;
    assign Result    = result_q;
    assign Cout      = cout_q;
    assign zero      = zero_q;
    assign neg       = neg_q;
    assign ovf       = ovf_q;
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed self-checking bench for alu_pipe
module tb_alu_pipe;
    logic        clk = 1'b0, rst = 1'b1;
    logic        in_valid = 1'b0, in_ready;
    logic [15:0] A = '0, B = '0;
    logic        Cin = 1'b0, use_acc = 1'b0;
    logic [2:0]  Control = '0;
    logic        out_valid, out_ready = 1'b1;
    logic [15:0] Result;
    logic        Cout, zero, neg, ovf;
    int          errors = 0, checks = 0;

    alu_pipe #(.WIDTH(16), .ACC_RST(16'h0000)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .Cin(Cin), .Control(Control), .use_acc(use_acc),
        .out_valid(out_valid), .out_ready(out_ready), .Result(Result),
        .Cout(Cout), .zero(zero), .neg(neg), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [15:0] r, input logic c, input logic z,
                           input logic n, input logic o);
        check({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, ".result"}, {16'd0, Result}, {16'd0, r});
        check({tag, ".cout"}, {31'd0, Cout}, {31'd0, c});
        check({tag, ".zero"}, {31'd0, zero}, {31'd0, z});
        check({tag, ".neg"}, {31'd0, neg}, {31'd0, n});
        check({tag, ".ovf"}, {31'd0, ovf}, {31'd0, o});
    endtask

    task automatic drive(input logic [2:0] ctl, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic ua);
        in_valid = 1'b1;
        Control  = ctl;
        A        = a;
        B        = b;
        Cin      = cin;
        use_acc  = ua;
    endtask

    task automatic run_op(input string tag, input logic [2:0] ctl, input logic [15:0] a,
                          input logic [15:0] b, input logic cin, input logic ua,
                          input logic [15:0] r, input logic c, input logic z,
                          input logic n, input logic o);
        drive(ctl, a, b, cin, ua);
        tick();
        in_valid = 1'b0;
        tick();
        chk_out(tag, r, c, z, n, o);
    endtask

    initial begin
        #1;
        check("rst.out_valid", {31'd0, out_valid}, 32'd0);
        check("rst.result", {16'd0, Result}, 32'd0);
        check("rst.flags", {28'd0, Cout, zero, neg, ovf}, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst.in_ready", {31'd0, in_ready}, 32'd1);
        check("rst.out_valid_after", {31'd0, out_valid}, 32'd0);

        // T1: latency and basic ADD
        drive(3'b000, 16'd2, 16'd1, 1'b1, 1'b0);
        tick();
        in_valid = 1'b0;
        check("t1.not_yet", {31'd0, out_valid}, 32'd0);
        tick();
        chk_out("t1.add", 16'd4, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check("t1.consumed", {31'd0, out_valid}, 32'd0);

        // T2: SUB borrow and equality
        run_op("t2.sub_borrow", 3'b001, 16'd1, 16'd2, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0);
        run_op("t2.sub_eq", 3'b001, 16'd5, 16'd5, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);

        // T3: signed overflow and unsigned wrap
        run_op("t3.add_ovf", 3'b000, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b1);
        run_op("t3.add_wrap", 3'b000, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
        run_op("t3.sub_ovf", 3'b001, 16'h8000, 16'h0001, 1'b0, 1'b0, 16'h7FFF, 1'b1, 1'b0, 1'b0, 1'b1);

        // T4: back-to-back accumulator chaining, shifts and logic ops
        drive(3'b000, 16'd3, 16'd4, 1'b0, 1'b0);
        tick();
        drive(3'b000, 16'd10, 16'h1234, 1'b0, 1'b1);
        tick();
        in_valid = 1'b0;
        chk_out("t4.chain0", 16'd7, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk_out("t4.chain1", 16'd17, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op("t4.shl", 3'b110, 16'h8001, 16'h0000, 1'b1, 1'b0, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0);
        run_op("t4.shr", 3'b111, 16'h0003, 16'h0000, 1'b0, 1'b0, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0);
        run_op("t4.and", 3'b010, 16'hF0F0, 16'hFF00, 1'b1, 1'b0, 16'hF000, 1'b0, 1'b0, 1'b1, 1'b0);
        run_op("t4.or", 3'b011, 16'h00F0, 16'h0F00, 1'b1, 1'b0, 16'h0FF0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op("t4.xor", 3'b100, 16'hFFFF, 16'h0F0F, 1'b0, 1'b0, 16'hF0F0, 1'b0, 1'b0, 1'b1, 1'b0);
        run_op("t4.not", 3'b101, 16'h0000, 16'h1111, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0);
        run_op("t4.sub_acc", 3'b001, 16'h0001, 16'h0000, 1'b0, 1'b1, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check("t4.drained", {31'd0, out_valid}, 32'd0);

        // T5: backpressure with three ops issued
        out_ready = 1'b0;
        drive(3'b000, 16'd1, 16'd1, 1'b0, 1'b0);
        tick();
        check("t5.ready_after1", {31'd0, in_ready}, 32'd1);
        drive(3'b000, 16'd2, 16'd2, 1'b0, 1'b0);
        tick();
        drive(3'b000, 16'd3, 16'd3, 1'b0, 1'b0);
        check("t5.ready_drop", {31'd0, in_ready}, 32'd0);
        chk_out("t5.hold0", 16'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        check("t5.ready_still_low", {31'd0, in_ready}, 32'd0);
        chk_out("t5.hold3", 16'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        out_ready = 1'b1;
        #1;
        check("t5.ready_release", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        chk_out("t5.second", 16'd4, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk_out("t5.third", 16'd6, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check("t5.empty", {31'd0, out_valid}, 32'd0);

        // T6: reset with two ops in flight
        drive(3'b000, 16'd9, 16'd9, 1'b0, 1'b0);
        tick();
        drive(3'b000, 16'd8, 16'd8, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;
        check("t6.inflight", {31'd0, out_valid}, 32'd1);
        rst = 1'b1;
        #1;
        check("t6.rst_valid", {31'd0, out_valid}, 32'd0);
        check("t6.rst_result", {16'd0, Result}, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        check("t6.no_ghost", {31'd0, out_valid}, 32'd0);
        run_op("t6.acc_reset", 3'b000, 16'd5, 16'h7777, 1'b0, 1'b1, 16'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
